// File: rtl/ip_pulse_sync_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ip_pulse_sync_pkg : shared state encoding, defaults and clog2 helper       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ip_pulse_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } state_e;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_TIMEOUT = 255;
  localparam int DEF_TO_W    = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ip_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ip_rr_arb : round-robin picker with registered search-start pointer        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ip_rr_arb
  import ip_pulse_sync_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = clog2(DEF_N_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             gnt_en_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o
);

  // ptr_q holds last_grant+1, so reset value 0 searches from requester 0
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0] upper;
  logic [N_REQ-1:0] pick;
  logic [ID_W-1:0]  idx;

  always_comb begin
    upper = '0;
    for (int i = 0; i < N_REQ; i++) begin
      upper[i] = req_i[i] && (ID_W'(i) >= ptr_q);
    end
    pick = (|upper) ? upper : req_i;
    idx  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pick[i]) idx = ID_W'(i);
    end
    ptr_d = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + ID_W'(1);
    gnt_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt_o[i] = gnt_en_i && (|req_i) && (idx == ID_W'(i));
    end
  end

  assign idx_o = idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (gnt_en_i && (|req_i)) begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ip_pulse_sync_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ip_pulse_sync_arb : round-robin scheduler sharing one pulse-sync channel   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ip_pulse_sync_arb
  import ip_pulse_sync_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int ID_W    = clog2(DEF_N_REQ),
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TO_W    = DEF_TO_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [N_REQ-1:0] i_req_pulse,
  input  logic             i_ch_ack,
  output logic             o_ch_pulse,
  output logic [ID_W-1:0]  o_ch_id,
  output logic             o_busy,
  output logic             o_done,
  output logic [ID_W-1:0]  o_done_id,
  output logic [N_REQ-1:0] o_pending,
  input  logic             i_drop_clr,
  output logic [N_REQ-1:0] o_drop,
  output logic             o_timeout
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e           state_q;
  logic [ID_W-1:0]  ch_id_q, done_id_q;
  logic             ch_pulse_q, done_q, timeout_q;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] drop_q, drop_d;
  logic [TO_W-1:0]  to_cnt_q;

  logic             grant;
  logic             to_hit;
  logic [N_REQ-1:0] gnt_oh;
  logic [ID_W-1:0]  gnt_idx;
  logic [N_REQ-1:0] new_drop;

  assign grant = (state_q == ST_IDLE) && i_en && (|pending_q);

  ip_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arb (
    .clk_i    (i_clk),
    .rst_i    (i_rst),
    .req_i    (pending_q),
    .gnt_en_i (grant),
    .gnt_o    (gnt_oh),
    .idx_o    (gnt_idx)
  );

  // A pulse on the bit being granted re-arms it rather than counting as a drop
  always_comb begin
    new_drop  = i_req_pulse & pending_q & ~gnt_oh;
    pending_d = (pending_q & ~gnt_oh) | i_req_pulse;
    drop_d    = (i_drop_clr ? '0 : drop_q) | new_drop;
    to_hit    = (TIMEOUT != 0) && (to_cnt_q == TO_LAST) &&
                ((state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      ch_id_q    <= '0;
      done_id_q  <= '0;
      ch_pulse_q <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      pending_q  <= '0;
      drop_q     <= '0;
      to_cnt_q   <= '0;
    end else begin
      pending_q  <= pending_d;
      drop_q     <= drop_d;
      ch_pulse_q <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= (timeout_q & ~i_drop_clr) | to_hit;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            state_q    <= ST_ISSUE;
            ch_id_q    <= gnt_idx;
            ch_pulse_q <= 1'b1;
            to_cnt_q   <= '0;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
          if (to_hit) begin
            state_q <= ST_IDLE;
          end else if (i_ch_ack) begin
            state_q <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
          if (to_hit) begin
            state_q <= ST_IDLE;
          end else if (!i_ch_ack) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b1;
            done_id_q <= ch_id_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ch_pulse = ch_pulse_q;
  assign o_ch_id    = ch_id_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = done_q;
  assign o_done_id  = done_id_q;
  assign o_pending  = pending_q;
  assign o_drop     = drop_q;
  assign o_timeout  = timeout_q;

endmodule
`default_nettype wire
